// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Types, constants and helpers shared by the UART transmit and
//            receive paths.
//  Contents: tx_state_t  - serializer state encoding
//            IDLE_LEVEL  - level of an idle serial line
//            parity_bit  - parity of a data word (even or odd)
//  Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Takes a zero-extended word so any DATA_BITS up to 64 can share one
  // function; the zero padding does not change the XOR reduction.
  function automatic logic parity_bit(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module  : uart_bit_timer
//  Purpose : Clock-cycle divider that marks the last cycle of each serial bit.
//  Ports   : Clock   - system clock (rising edge)
//            Reset   - synchronous active-high reset
//            Restart - holds the count at zero; counting starts when released
//            BitEnd  - high in the final cycle of every CLKS_PER_BIT period
//  Revision: 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Restart,
  output logic BitEnd
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Free-running wrap keeps consecutive bits exactly CLKS_PER_BIT apart
  // without any re-arm from the consumer.
  always_comb begin
    cnt_d = cnt_q;
    if (Restart || (cnt_q == TERMINAL)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign BitEnd = (cnt_q == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : uart_tx_serializer
//  Purpose : Pops bytes from the TX FIFO and serialises them as
//            start / LSB-first data / optional parity / stop bit(s).
//  Ports   : Clock     - system clock (rising edge)
//            Reset     - synchronous active-high reset
//            TxEnable  - permits starting a new frame
//            FifoEmpty - FIFO empty flag
//            FifoData  - head-of-FIFO data (valid while FifoEmpty=0)
//            FifoRead  - one-cycle pop strobe to the FIFO
//            Tx        - serial output, idles high
//            Busy      - high while a frame is in progress
//            TxDone    - one-cycle pulse after the last stop bit
//  Revision: 1.0 - initial release
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 TxEnable,
  input  logic                 FifoEmpty,
  input  logic [DATA_BITS-1:0] FifoData,
  output logic                 FifoRead,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 TxDone
);

  localparam int               IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] data_q,  data_d;   // byte latched on the pop edge
  logic [IDX_W-1:0]     idx_q,   idx_d;    // data bit index, reused as stop bit count
  logic                 tx_q,    tx_d;
  logic                 read_q,  read_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;

  logic                 bit_end;
  logic                 timer_restart;
  logic                 par_bit;

  // Holding the timer in reset while idle aligns every bit period to the
  // pop edge, so the start bit lasts exactly CLKS_PER_BIT cycles.
  assign timer_restart = (state_q == TX_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .Restart(timer_restart),
    .BitEnd (bit_end)
  );

  assign par_bit = parity_bit(64'(data_q), (PARITY_ODD != 0));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    read_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      TX_IDLE: begin
        tx_d  = IDLE_LEVEL;
        idx_d = '0;
        // FifoEmpty is only looked at here, so the FIFO's flag lag after a
        // pop can never trigger a second read for the same frame.
        if (TxEnable && !FifoEmpty) begin
          data_d  = FifoData;
          state_d = TX_START;
          tx_d    = 1'b0;
          read_d  = 1'b1;
        end
      end

      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end

      TX_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = TX_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = TX_STOP;
              tx_d    = IDLE_LEVEL;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = data_q[idx_d];
          end
        end
      end

      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          idx_d   = '0;
          tx_d    = IDLE_LEVEL;
        end
      end

      TX_STOP: begin
        tx_d = IDLE_LEVEL;
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            state_d = TX_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = TX_IDLE;
        idx_d   = '0;
        tx_d    = IDLE_LEVEL;
      end
    endcase

    busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= TX_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign FifoRead = read_q;
  assign Tx       = tx_q;
  assign Busy     = busy_q;
  assign TxDone   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_tx_serializer
//  Purpose : Self-checking bench for uart_tx_serializer. Three instances:
//            0 - no parity, 1 stop; 1 - even parity, 1 stop;
//            2 - odd parity, 2 stops. Each has its own behavioural FIFO.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en      [3];
  logic       emptyv  [3];
  logic [7:0] datav   [3];
  logic       rdv     [3];
  logic       txv     [3];
  logic       busyv   [3];
  logic       donev   [3];

  logic [7:0] mem [3][16];
  int         wp  [3];
  int         rp  [3];
  int         cyc = 0;

  logic [7:0] exp_q [$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: combinational head/empty, pop on the edge after FifoRead.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdv[i] === 1'b1) rp[i] <= rp[i] + 1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    assign emptyv[g] = (wp[g] == rp[g]);
    assign datav[g]  = mem[g][rp[g] % 16];
  end

  uart_tx_serializer #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_dut0 (
    .Clock(clk), .Reset(rst), .TxEnable(en[0]), .FifoEmpty(emptyv[0]),
    .FifoData(datav[0]), .FifoRead(rdv[0]), .Tx(txv[0]), .Busy(busyv[0]), .TxDone(donev[0])
  );

  uart_tx_serializer #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut1 (
    .Clock(clk), .Reset(rst), .TxEnable(en[1]), .FifoEmpty(emptyv[1]),
    .FifoData(datav[1]), .FifoRead(rdv[1]), .Tx(txv[1]), .Busy(busyv[1]), .TxDone(donev[1])
  );

  uart_tx_serializer #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)
  ) u_dut2 (
    .Clock(clk), .Reset(rst), .TxEnable(en[2]), .FifoEmpty(emptyv[2]),
    .FifoData(datav[2]), .FifoRead(rdv[2]), .Tx(txv[2]), .Busy(busyv[2]), .TxDone(donev[2])
  );

  task automatic push(input int i, input logic [7:0] b, input bit score);
    mem[i][wp[i] % 16] = b;
    wp[i] = wp[i] + 1;
    if (score) exp_q.push_back(b);
  endtask

  // Waits for the next start bit on instance i and checks the whole frame
  // cycle by cycle against the next scoreboard byte. Returns at the cycle
  // after the last stop bit, where TxDone must be high.
  task automatic capture_frame(input int i, input int par_en, input int par_odd,
                               input int stops, output int start_cyc);
    logic [7:0] b;
    logic       exp_bits [$];
    int         nb;
    int         waited;
    logic       bad_tx;
    logic       bad_ctl;
    logic       got_tx;
    logic       rd_exp;
    start_cyc = -1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty inst=%0d got 0 entries want >=1", i);
      return;
    end
    tests--;
    b = exp_q.pop_front();
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
    if (par_en != 0) exp_bits.push_back((^b) ^ par_odd[0]);
    for (int k = 0; k < stops; k++) exp_bits.push_back(1'b1);
    nb = exp_bits.size();

    waited = 0;
    while (txv[i] !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) begin
      tests++;
      fails++;
      $display("FAIL start_timeout inst=%0d byte=%h got no start want start", i, b);
      return;
    end
    start_cyc = cyc;

    bad_ctl = 1'b0;
    for (int k = 0; k < nb; k++) begin
      bad_tx = 1'b0;
      got_tx = exp_bits[k];
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (txv[i] !== exp_bits[k]) begin
          bad_tx = 1'b1;
          got_tx = txv[i];
        end
        rd_exp = (k == 0 && c == 0) ? 1'b1 : 1'b0;
        if (busyv[i] !== 1'b1 || donev[i] !== 1'b0 || rdv[i] !== rd_exp) bad_ctl = 1'b1;
      end
      tests++;
      if (bad_tx) begin
        fails++;
        $display("FAIL frame_bit inst=%0d byte=%h bit=%0d got tx=%b want tx=%b",
                 i, b, k, got_tx, exp_bits[k]);
      end
    end
    tests++;
    if (bad_ctl) begin
      fails++;
      $display("FAIL frame_ctl inst=%0d byte=%h got busy/done/read off-pattern want busy=1 done=0 read=1 only in cycle 1",
               i, b);
    end
    @(negedge clk);
    tests++;
    if (donev[i] !== 1'b1 || busyv[i] !== 1'b0 || txv[i] !== 1'b1) begin
      fails++;
      $display("FAIL frame_end inst=%0d byte=%h got done=%b busy=%b tx=%b want 1 0 1",
               i, b, donev[i], busyv[i], txv[i]);
    end
  endtask

  task automatic check_quiet(input int i, input int ncyc, input string name);
    logic bad;
    bad = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (txv[i] !== 1'b1 || busyv[i] !== 1'b0 || rdv[i] !== 1'b0 || donev[i] !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s inst=%0d got activity on tx/busy/read/done want tx=1 busy=0 read=0 done=0",
               name, i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (txv[i] !== 1'b1 || busyv[i] !== 1'b0 || rdv[i] !== 1'b0 || donev[i] !== 1'b0) begin
          fails++;
          $display("FAIL reset_idle inst=%0d cyc=%0d got tx=%b busy=%b read=%b done=%b want 1 0 0 0",
                   i, c, txv[i], busyv[i], rdv[i], donev[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    int s;
    push(0, 8'hA5, 1'b1);
    capture_frame(0, 0, 0, 1, s);
    check_quiet(0, 5, "single_after");
  endtask

  task automatic test_back_to_back();
    int s0;
    int s1;
    push(0, 8'h01, 1'b1);
    push(0, 8'hFF, 1'b1);
    capture_frame(0, 0, 0, 1, s0);
    capture_frame(0, 0, 0, 1, s1);
    tests++;
    if (s1 - s0 != 41) begin
      fails++;
      $display("FAIL b2b_period got %0d cycles want 41", s1 - s0);
    end
    check_quiet(0, 5, "b2b_after");
  endtask

  task automatic test_parity();
    int s0;
    int s1;
    push(1, 8'h07, 1'b1);
    capture_frame(1, 1, 0, 1, s0);
    push(2, 8'h07, 1'b1);
    capture_frame(2, 1, 1, 2, s1);
    check_quiet(2, 5, "parity_after");
  endtask

  task automatic test_reset_mid();
    int s;
    int waited;
    push(0, 8'h3C, 1'b0);
    push(0, 8'h55, 1'b1);
    waited = 0;
    while (txv[0] !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (waited >= 100) begin
      fails++;
      $display("FAIL reset_mid_start got no start want start");
    end
    // First start-bit negedge is frame cycle 1; data bit 3 spans cycles 17..20.
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (txv[0] !== 1'b1 || busyv[0] !== 1'b0 || donev[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got tx=%b busy=%b done=%b want 1 0 0", txv[0], busyv[0], donev[0]);
    end
    rst = 1'b0;
    capture_frame(0, 0, 0, 1, s);
    tests++;
    if (rp[0] != wp[0]) begin
      fails++;
      $display("FAIL reset_mid_pops got rp=%0d want %0d", rp[0], wp[0]);
    end
  endtask

  task automatic test_enable();
    int s;
    en[0] = 1'b0;
    push(0, 8'h5A, 1'b1);
    push(0, 8'hC3, 1'b1);
    check_quiet(0, 20, "enable_low_idle");
    en[0] = 1'b1;
    fork
      capture_frame(0, 0, 0, 1, s);
      begin
        repeat (10) @(negedge clk);
        en[0] = 1'b0;
      end
    join
    check_quiet(0, 20, "enable_drop_no_pop");
    tests++;
    if (wp[0] - rp[0] != 1) begin
      fails++;
      $display("FAIL enable_fifo_level got %0d want 1", wp[0] - rp[0]);
    end
    en[0] = 1'b1;
    capture_frame(0, 0, 0, 1, s);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b1;
      wp[i] = 0;
      rp[i] = 0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit stage that sits directly downstream of the TX FIFO. It pops one byte at a time using the FIFO's Empty/Read/ReadData handshake and serialises each byte onto the Tx line as start bit, LSB-first data, optional parity, and stop bit(s). Bit timing comes from an internal clock-cycle divider; no external baud tick is used.

Parameters:
DATA_BITS, 8, data bits per frame; must match the FIFO WIDTH.
CLKS_PER_BIT, 434, Clock cycles per serial bit; must be >= 2 (434 = 50 MHz / 115200).
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.

Ports:
Clock  input  1  system clock; all logic is on the rising edge.
Reset  input  1  synchronous, active-high reset.
TxEnable  input  1  when low, no new frame is started; a frame already in flight always completes.
FifoEmpty  input  1  FIFO Empty flag.
FifoData  input  DATA_BITS  FIFO ReadData; combinational head-of-FIFO value, valid while FifoEmpty=0.
FifoRead  output  DATA_BITS-independent 1  pop strobe to the FIFO Read input.
Tx  output  1  serial line; idles high.
Busy  output  1  high whenever the state is not IDLE.
TxDone  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are Clock and Reset.
- Reset values: Tx=1, FifoRead=0, Busy=0, TxDone=0, state=IDLE, all counters 0.
- All outputs are registered.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: on an edge where TxEnable=1 and FifoEmpty=0:
  - shift register <= FifoData;
  - state <= START; Tx <= 0;
  - FifoRead <= 1 for exactly one cycle, so the FIFO pops on the following edge.
  - FifoEmpty is sampled only in IDLE, so the FIFO's one-cycle flag lag cannot cause a double pop.
- Bit timing: each bit is held for exactly CLKS_PER_BIT cycles.
  - Bit-cycle counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and the bit advances on terminal count.
- DATA: shift out LSB first for DATA_BITS bits. The bit index counter has width $clog2(DATA_BITS).
- PARITY: present only if PARITY_EN=1.
  - Bit value = XOR of the latched data byte, inverted when PARITY_ODD=1.
  - Parity is computed from the latched byte, never from FifoData.
- STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final edge: state <= IDLE and TxDone <= 1 for one cycle.
- Frame length, start bit to end of last stop bit: L = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: exactly one IDLE cycle (Tx=1) separates frames.
  - Start-to-start period is L+1 when the FIFO stays non-empty.
- TxEnable deasserted mid-frame: the frame completes normally, and no new pop occurs until TxEnable=1.
- Reset mid-frame:
  - next cycle Tx=1, Busy=0, state=IDLE; no TxDone is issued;
  - the byte already popped is discarded;
  - the FIFO is not re-popped for it.
- FifoData is never sampled outside the IDLE pop edge. Changes to it mid-frame have no effect.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP};
  - localparam IDLE_LEVEL = 1'b1;
  - a function for the parity bit (data, odd).
  - The package is shared with the future receiver.
- One sub-module: uart_bit_timer.
  - Parameterised by CLKS_PER_BIT; inputs Clock, Reset, Restart; output BitEnd (terminal-count pulse).
  - Reused by the receiver.

Test Plan:
Use CLKS_PER_BIT=4 and DATA_BITS=8 unless noted, with a behavioural FIFO model driving FifoEmpty/FifoData.
1. Reset held 2 cycles, FIFO empty -> Tx=1, Busy=0, FifoRead=0, TxDone=0 throughout, and for 20 cycles after release.
2. Single byte 8'hA5 -> one FifoRead pulse, then Tx = 0 (4 cycles), then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles). Busy is high for 40 cycles and TxDone pulses once at cycle 40.
3. FIFO holds 8'h01 and 8'hFF -> two FifoRead pulses 41 cycles apart, with one idle-high cycle between the stop bit and the second start bit.
4. PARITY_EN=1 with 8'h07:
   - even parity -> parity bit 1, frame 44 cycles;
   - PARITY_ODD=1 -> parity bit 0;
   - adding STOP_BITS=2 -> frame 48 cycles, stop high for 8 cycles.
5. Reset asserted during data bit 3 of 8'h3C -> next cycle Tx=1 and Busy=0, no TxDone. After release, the next FIFO entry 8'h55 is sent as a clean full frame.
6. TxEnable=0 with a non-empty FIFO -> no FifoRead and Tx stays 1. Drop TxEnable mid-frame -> the current frame finishes with TxDone, and no further pop occurs.
